// File: rtl/v_upd_tx.sv
// List update bus transmitter: in-order FIFO plus same-product issue spacing.
// Latency: 2 cycles push-to-issue when idle. Backpressure: o_cmd_rdy low only when FIFO full or in reset.

// Generic synchronous FIFO; head is combinational from storage, occupancy registered.
// Latency: entry visible at head the cycle after its write. Backpressure: caller must not push when full.
module v_upd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   level_r
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_r <= level_r + 1'b1;
                2'b01:   level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module v_upd_tx #(
    parameter int ID_W   = 8,
    parameter int CMD_W  = 2,
    parameter int KEY_W  = 16,
    parameter int SIZE_W = 16,
    parameter int DEPTH  = 8,
    parameter int GAP    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_cmd_vld,
    output logic                      o_cmd_rdy,
    input  logic [ID_W-1:0]           i_cmd_prod_id,
    input  logic [CMD_W-1:0]          i_cmd_cmd,
    input  logic [KEY_W-1:0]          i_cmd_key,
    input  logic [SIZE_W-1:0]         i_cmd_size,
    input  logic                      i_busy,
    output logic                      o_upd_vld_r,
    output logic [ID_W-1:0]           o_upd_prod_id_r,
    output logic [CMD_W-1:0]          o_upd_cmd_r,
    output logic [KEY_W-1:0]          o_upd_key_r,
    output logic [SIZE_W-1:0]         o_upd_size_r,
    output logic [$clog2(DEPTH):0]    o_level_r,
    output logic [15:0]               o_stall_cnt_r
);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ID_W-1:0]   prod_id;
        logic [CMD_W-1:0]  cmd;
        logic [KEY_W-1:0]  key;
        logic [SIZE_W-1:0] size;
    } upd_t;

    upd_t cmd_dat;
    upd_t head_dat;
    logic push;
    logic pop;
    logic nonempty;
    logic hazard;

    assign cmd_dat   = '{prod_id: i_cmd_prod_id, cmd: i_cmd_cmd, key: i_cmd_key, size: i_cmd_size};
    assign o_cmd_rdy = rst && (o_level_r != LW'(DEPTH));
    assign push      = i_cmd_vld && o_cmd_rdy;
    assign nonempty  = (o_level_r != '0);
    assign pop       = nonempty && !i_busy && !hazard;

    v_upd_fifo #(
        .W     ($bits(upd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (cmd_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .level_r  (o_level_r)
    );

    // Entry 0 mirrors the bus currently driven; older issues age toward GAP-1.
    if (GAP > 0) begin : g_hist
        logic [GAP-1:0]  hist_vld;
        logic [ID_W-1:0] hist_id [GAP];
        logic            hit;

        always_ff @(posedge clk) begin
            if (!rst) begin
                hist_vld <= '0;
                for (int i = 0; i < GAP; i++) begin
                    hist_id[i] <= '0;
                end
            end else begin
                for (int i = GAP - 1; i > 0; i--) begin
                    hist_vld[i] <= hist_vld[i-1];
                    hist_id[i]  <= hist_id[i-1];
                end
                hist_vld[0] <= pop;
                hist_id[0]  <= head_dat.prod_id;
            end
        end

        always_comb begin
            hit = 1'b0;
            for (int i = 0; i < GAP; i++) begin
                if (hist_vld[i] && (hist_id[i] == head_dat.prod_id)) begin
                    hit = 1'b1;
                end
            end
        end

        assign hazard = nonempty && hit;
    end else begin : g_no_hist
        assign hazard = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            o_upd_vld_r     <= 1'b0;
            o_upd_prod_id_r <= '0;
            o_upd_cmd_r     <= '0;
            o_upd_key_r     <= '0;
            o_upd_size_r    <= '0;
        end else begin
            o_upd_vld_r <= pop;
            if (pop) begin
                o_upd_prod_id_r <= head_dat.prod_id;
                o_upd_cmd_r     <= head_dat.cmd;
                o_upd_key_r     <= head_dat.key;
                o_upd_size_r    <= head_dat.size;
            end
        end
    end

    // Busy cycles are not hazard stalls; only cycles lost to spacing count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_stall_cnt_r <= '0;
        end else if (nonempty && !i_busy && hazard && (o_stall_cnt_r != 16'hFFFF)) begin
            o_stall_cnt_r <= o_stall_cnt_r + 16'd1;
        end
    end
endmodule
